risc_core_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 16-bit ALU/register-file processor. It accepts one instruction at a time over a valid/ready handshake. It executes ALU, shift, LOAD and STORE operations through an explicit FSM, and drives a real request/acknowledge data-memory port instead of bare read/write strobes. It sits between the instruction source (testbench or future fetch unit) and the data memory. It also adds reset, completion signalling and illegal-opcode detection.

---
 rtl/risc_pkg.sv | 60 ++++++
 rtl/risc_regfile.sv | 31 +++
 rtl/risc_core_mc.sv | 153 +++++++++++++++
 tb/tb_risc_core_mc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared types and decode helpers for the multi-cycle core.
//   opcode_e  - 4-bit opcode encoding (0 and 11..15 are illegal)
//   state_e   - control FSM states
//   alu_op_e  - internal ALU operation select
//   is_legal / writes_rd / alu_decode - opcode decode helpers
package risc_pkg;

  localparam int OP_W = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_NOT   = 4'd6,
    OP_LOAD  = 4'd7,
    OP_STORE = 4'd8,
    OP_SHL   = 4'd9,
    OP_SHR   = 4'd10
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT,
    ALU_SHL, ALU_SHR, ALU_PASSA, ALU_PASSB, ALU_NONE
  } alu_op_e;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op >= 4'd1) && (op <= 4'd10);
  endfunction

  // STORE is the only legal opcode that leaves the register file alone.
  function automatic logic writes_rd(input logic [OP_W-1:0] op);
    return is_legal(op) && (op != OP_STORE);
  endfunction

  function automatic alu_op_e alu_decode(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:   return ALU_ADD;
      OP_SUB:   return ALU_SUB;
      OP_AND:   return ALU_AND;
      OP_OR:    return ALU_OR;
      OP_XOR:   return ALU_XOR;
      OP_NOT:   return ALU_NOT;
      OP_SHL:   return ALU_SHL;
      OP_SHR:   return ALU_SHR;
      OP_LOAD:  return ALU_PASSA;  // address
      OP_STORE: return ALU_PASSB;  // store data
      default:  return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/risc_regfile.sv
// risc_regfile: NREG x DATA_W register file.
//   i_clk/i_rst_n     - clock, async active-low clear of every register
//   i_we/i_waddr/i_wdata - synchronous write port
//   i_raddr1/o_rdata1, i_raddr2/o_rdata2 - asynchronous read ports
module risc_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int RA_W  = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [RA_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [RA_W-1:0]   i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic [RA_W-1:0]   i_raddr2,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [NREG-1:0][DATA_W-1:0] r_regs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_regs <= '0;
    else if (i_we) r_regs[i_waddr] <= i_wdata;
  end

  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/risc_core_mc.sv
// risc_core_mc: multi-cycle ALU / load-store core, one instruction in flight.
//   clk, rst_n               - clock, async active-low reset
//   instr/instr_valid/instr_ready - instruction handshake (sampled on acceptance)
//   done/result/zero/illegal - retire pulse and retiring-instruction status
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata - data-memory port
module risc_core_mc
  import risc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               illegal,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int RA_W  = $clog2(NREG);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int FLD_W = OP_W + 3 * RA_W;

  if (INSTR_W < FLD_W) begin : g_bad_instr_w
    $error("risc_core_mc: INSTR_W too small for opcode + 3 register fields");
  end

  // Only the decoded fields are kept; the low padding bits never matter.
  if (INSTR_W > FLD_W) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^instr[INSTR_W-FLD_W-1:0];
  end

  state_e              r_state, w_next;
  logic [FLD_W-1:0]    r_instr;
  logic [OP_W-1:0]     w_op;
  logic [RA_W-1:0]     w_rs1, w_rs2, w_rd;
  logic [DATA_W-1:0]   w_a, w_b, w_alu;
  logic                w_is_mem;
  logic [DATA_W-1:0]   r_result, r_mem_addr, r_mem_wdata;
  logic                r_zero, r_mem_we;

  assign w_op     = r_instr[FLD_W-1 -: OP_W];
  assign w_rs1    = r_instr[FLD_W-OP_W-1 -: RA_W];
  assign w_rs2    = r_instr[FLD_W-OP_W-RA_W-1 -: RA_W];
  assign w_rd     = r_instr[RA_W-1:0];
  assign w_is_mem = (w_op == OP_LOAD) || (w_op == OP_STORE);

  // Write data is r_result: every rd-writing opcode has just loaded it on WB entry.
  risc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_we     ((r_state == S_WB) && writes_rd(w_op)),
    .i_waddr  (w_rd),
    .i_wdata  (r_result),
    .i_raddr1 (w_rs1),
    .o_rdata1 (w_a),
    .i_raddr2 (w_rs2),
    .o_rdata2 (w_b)
  );

  always_comb begin
    w_alu = '0;
    case (alu_decode(w_op))
      ALU_ADD:   w_alu = w_a + w_b;
      ALU_SUB:   w_alu = w_a - w_b;
      ALU_AND:   w_alu = w_a & w_b;
      ALU_OR:    w_alu = w_a | w_b;
      ALU_XOR:   w_alu = w_a ^ w_b;
      ALU_NOT:   w_alu = ~w_a;
      ALU_SHL:   w_alu = w_a << w_b[SH_W-1:0];
      ALU_SHR:   w_alu = w_a >> w_b[SH_W-1:0];
      ALU_PASSA: w_alu = w_a;
      ALU_PASSB: w_alu = w_b;
      default:   w_alu = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (instr_valid) w_next = S_EXEC;
      S_EXEC: w_next = w_is_mem ? S_MEM : S_WB;
      S_MEM:  if (mem_ack) w_next = S_WB;
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs. Handshake/strobes decode straight from state so reset
  // drops mem_req without waiting for an edge.
  always_comb begin
    instr_ready = (r_state == S_IDLE);
    mem_req     = (r_state == S_MEM);
    done        = (r_state == S_WB);
    illegal     = (r_state == S_WB) && !is_legal(w_op);
  end

  // Datapath registers. result/zero load on the edge entering WB so they are
  // valid in the same cycle as done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr     <= '0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (instr_valid) r_instr <= instr[INSTR_W-1 -: FLD_W];
        S_EXEC: begin
          r_mem_addr  <= w_a;
          r_mem_wdata <= w_b;
          r_mem_we    <= (w_op == OP_STORE);
          if (!w_is_mem && is_legal(w_op)) begin
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
          end
        end
        S_MEM: if (mem_ack) begin
          r_result <= r_mem_we ? r_mem_wdata : mem_rdata;
          r_zero   <= ((r_mem_we ? r_mem_wdata : mem_rdata) == '0);
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign zero      = r_zero;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_risc_core_mc.sv
// tb_risc_core_mc: scoreboard bench for risc_core_mc (default parameters).
module tb_risc_core_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready, done, zero, illegal;
  logic [15:0] result, mem_addr, mem_wdata, mem_rdata = '0;
  logic        mem_req, mem_we, mem_ack = 1'b0;

  risc_core_mc #(.DATA_W(16), .NREG(8), .INSTR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .result(result), .zero(zero),
    .illegal(illegal), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_pass = 0;
  int          ncyc = 0, acc_cyc = 0, acc_cnt = 0, done_cnt = 0;
  logic [15:0] regs_m [8];
  logic [15:0] last_res = '0;
  logic        last_z = 1'b1;
  logic        exp_mem = 1'b0, exp_we = 1'b0;
  logic [15:0] exp_addr = '0, exp_wdata = '0, cur_ld = '0;
  int          cur_k = 1, mem_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one instruction; called just after a rising edge, returns just
  // after the acceptance edge. keep=1 leaves instr_valid high for the next.
  task automatic issue(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input int k, input logic [15:0] ld, input bit keep);
    exp_t e;
    logic [15:0] a, b, v;
    bit ok;
    instr = {op, rs1, rs2, rd, 3'($urandom)};
    instr_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (instr_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    chk("one_in_flight", q.size(), 0);
    a = regs_m[rs1];
    b = regs_m[rs2];
    case (op)
      4'd1:  v = a + b;
      4'd2:  v = a - b;
      4'd3:  v = a & b;
      4'd4:  v = a | b;
      4'd5:  v = a ^ b;
      4'd6:  v = ~a;
      4'd7:  v = ld;
      4'd8:  v = b;
      4'd9:  v = a << b[3:0];
      4'd10: v = a >> b[3:0];
      default: v = last_res;
    endcase
    e.ill = !(op >= 4'd1 && op <= 4'd10);
    if (!e.ill) begin
      last_res = v;
      last_z = (v == 16'h0);
      if (op != 4'd8) regs_m[rd] = v;
    end
    e.res = last_res;
    e.z = last_z;
    e.lat = (op == 4'd7 || op == 4'd8) ? 3 + k : 3;
    exp_mem = (op == 4'd7 || op == 4'd8);
    exp_we = (op == 4'd8);
    exp_addr = a;
    exp_wdata = b;
    cur_k = k;
    cur_ld = ld;
    q.push_back(e);
    @(posedge clk); #1;
    if (!keep) begin
      instr_valid = 1'b0;
      instr = 16'($urandom);  // must be ignored after acceptance
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                     input logic [2:0] rd, input int k, input logic [15:0] ld);
    issue(op, rs1, rs2, rd, k, ld, 1'b0);
    wait_done();
  endtask

  // Retire monitor / scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst_n && instr_valid && instr_ready) begin
      acc_cyc = ncyc;
      acc_cnt++;
    end
    if (done) begin
      done_cnt++;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("zero", zero, e.z);
        chk("illegal", illegal, e.ill);
        chk("latency", ncyc - acc_cyc + 1, e.lat);
      end
    end else if (illegal) chk("illegal_without_done", 1, 0);
  end

  // Data-memory model: acks in the cur_k-th MEM cycle, drives noise otherwise.
  always @(negedge clk) begin
    if (rst_n && mem_req) begin
      mem_cnt++;
      chk("mem_req_expected", exp_mem, 1);
      chk("mem_we", mem_we, exp_we);
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wdata", mem_wdata, exp_wdata);
      if (mem_cnt == cur_k) begin
        mem_ack = 1'b1;
        mem_rdata = cur_ld;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
      end
    end else begin
      mem_cnt = 0;
      mem_ack = 1'($urandom);
      mem_rdata = 16'($urandom);
    end
  end

  initial begin
    logic [3:0] ops [12];
    for (int i = 0; i < 8; i++) regs_m[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(4'd1, 3'd0, 3'd0, 3'd3, 1, 16'h0);       // ADD r3 = r0+r0
    run(4'd7, 3'd0, 3'd0, 3'd1, 1, 16'h0005);    // LOAD r1
    run(4'd7, 3'd0, 3'd0, 3'd2, 2, 16'h0003);    // LOAD r2
    run(4'd2, 3'd1, 3'd2, 3'd4, 1, 16'h0);       // SUB  -> 0002
    run(4'd2, 3'd2, 3'd1, 3'd5, 1, 16'h0);       // SUB  -> FFFE
    run(4'd5, 3'd1, 3'd2, 3'd6, 1, 16'h0);       // XOR  -> 0006
    run(4'd6, 3'd1, 3'd0, 3'd7, 1, 16'h0);       // NOT  -> FFFA
    run(4'd9, 3'd1, 3'd2, 3'd4, 1, 16'h0);       // SHL  -> 0028
    run(4'd10, 3'd7, 3'd2, 3'd0, 1, 16'h0);      // SHR  -> 1FFF
    run(4'd3, 3'd5, 3'd7, 3'd0, 1, 16'h0);       // AND
    run(4'd4, 3'd1, 3'd2, 3'd6, 1, 16'h0);       // OR
    run(4'd8, 3'd1, 3'd2, 3'd0, 4, 16'h0);       // STORE, ack after 4 MEM cycles
    run(4'hF, 3'd1, 3'd2, 3'd1, 1, 16'h0);       // illegal
    run(4'h0, 3'd3, 3'd3, 3'd2, 1, 16'h0);       // illegal
    run(4'd4, 3'd1, 3'd1, 3'd1, 1, 16'h0);       // r1 unchanged?
    run(4'd4, 3'd2, 3'd2, 3'd2, 1, 16'h0);       // r2 unchanged?
    run(4'd1, 3'd1, 3'd1, 3'd1, 1, 16'h0);       // rd == rs1
    run(4'd4, 3'd1, 3'd1, 3'd0, 1, 16'h0);

    // Back-to-back with instr_valid held high.
    ops = '{4'd1, 4'd7, 4'd2, 4'd9, 4'd8, 4'hD, 4'd10, 4'd5, 4'd7, 4'd6, 4'd3, 4'd4};
    for (int i = 0; i < 12; i++)
      issue(ops[i], 3'($urandom), 3'($urandom), 3'($urandom),
            int'($urandom_range(1, 3)), 16'($urandom), (i != 11));
    wait_done();

    // Reset while in MEM.
    issue(4'd7, 3'd1, 3'd2, 3'd5, 1000, 16'h1234, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mem_req_before_reset", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_ready", instr_ready, 1);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    q.delete();
    for (int i = 0; i < 8; i++) regs_m[i] = '0;
    last_res = '0;
    last_z = 1'b1;
    exp_mem = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", instr_ready, 1);
    for (int i = 0; i < 8; i++) run(4'd4, 3'(i), 3'(i), 3'(i), 1, 16'h0);

    chk("accepts_vs_retires", acc_cnt, done_cnt + 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
